// File: rtl/ccs_fifo_stage.sv
// Elastic rdy/vld/dat buffer between a ccs initiator (upstream) and a ccs responder (downstream).
// Latency: 1 cycle minimum (word pushed at edge N is presented after edge N); no same-cycle bypass.
// Backpressure: in_rdy drops only when all DEPTH entries are occupied; out_rdy never reaches in_rdy combinationally.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_vld/in_rdy/in_dat    upstream link (this block is the responder)
//   out_vld/out_rdy/out_dat downstream link (this block is the initiator)
//   level             current occupancy, 0..DEPTH
//   hwm, hwm_clr      high-water mark of level and its one-cycle restart pulse
//
// DEPTH must be a power of two and at least 2 so the pointers wrap for free.

module ccs_fifo_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] hwm,
    input  logic             hwm_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             push;
    logic             pop;

    // Both handshake outputs depend only on registered occupancy (and rst),
    // which keeps the two links free of combinational paths between them.
    assign in_rdy  = !rst && (level != LVL_W'(DEPTH));
    assign out_vld = (level != '0);
    assign out_dat = mem[rd_ptr];

    assign push = in_vld && in_rdy;
    assign pop  = out_vld && out_rdy;

    assign level_next = level + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            hwm    <= '0;
            // Clearing storage guarantees out_dat reads 0 after reset
            // instead of a stale word from before the reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            // A clear restarts tracking from the occupancy that results from this edge.
            if (hwm_clr) begin
                hwm <= level_next;
            end else if (level_next > hwm) begin
                hwm <= level_next;
            end
        end
    end

endmodule

// File: doc/ccs_fifo_stage.md
Name: ccs_fifo_stage

Overview:
- Elastic buffer placed between two ccs rdy/vld/dat links.
- Upstream side is a ccs responder; it accepts words from a ccs initiator.
- Downstream side is a ccs initiator; it presents words to the next ccs responder.
- Decouples back-pressure, sustains one word per clock, and reports occupancy plus a clearable high-water mark for test/debug.

Parameters:
- WIDTH, 32, data bits per ccs word.
- DEPTH, 4, number of storage entries. Must be a power of two and at least 2.
- LVL_W, $clog2(DEPTH+1), derived local width of level/hwm. Not overridable.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  1  upstream word valid.
- in_rdy  output  1  upstream ready; this block is the ccs responder.
- in_dat  input  WIDTH  upstream data.
- out_vld  output  1  downstream word valid; this block is the ccs initiator.
- out_rdy  input  1  downstream ready.
- out_dat  output  WIDTH  downstream data.
- level  output  LVL_W  current occupancy, 0..DEPTH.
- hwm  output  LVL_W  high-water mark of level since reset or last clear.
- hwm_clr  input  1  one-cycle pulse that restarts the high-water mark.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. No asynchronous paths.
- Transfer rules:
  - push = in_vld & in_rdy; pop = out_vld & out_rdy.
  - A transfer occurs only on a clock edge where both vld and rdy are high.
- Storage:
  - DEPTH-entry register array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - level register tracks occupancy.
- Combinational outputs:
  - in_rdy = !rst & (level != DEPTH).
  - out_vld = (level != 0).
  - out_dat = mem[rd_ptr] (first-word fall-through from storage).
- No combinational path from out_rdy to in_rdy, and none from in_vld/in_dat to out_vld/out_dat.
- Latency: a word pushed at edge N is presented on out_vld/out_dat after edge N. Minimum latency is 1 cycle; there is no same-cycle bypass when empty.
- Throughput: with level in 1..DEPTH-1 and both sides active, one push and one pop per cycle; level is unchanged.
- Update per edge when not in reset:
  - push writes in_dat to mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - level_next = level + push - pop.
- Full (level == DEPTH):
  - in_rdy = 0, so no push.
  - A pop still occurs if out_rdy = 1; in_rdy rises the following cycle.
- Empty (level == 0):
  - out_vld = 0, so no pop.
  - A push makes out_vld = 1 after the edge.
- Data hold: out_dat is stable while out_vld = 1 and out_rdy = 0. Ordering is strictly FIFO.
- High-water mark:
  - If hwm_clr = 1: hwm <= level_next.
  - Otherwise: hwm <= max(hwm, level_next).
  - hwm_clr takes precedence over the max update.
- Reset (rst high at an edge):
  - wr_ptr, rd_ptr, level and hwm go to 0.
  - All mem entries are cleared to 0.
  - in_vld, out_rdy and hwm_clr are ignored on that edge.
  - While rst is high, in_rdy = 0.
- Reset values of outputs: in_rdy 0 during rst, 1 on the first cycle after rst deasserts; out_vld 0; out_dat 0; level 0; hwm 0.
- Reset asserted mid-stream discards all buffered words. No partial word is presented afterwards.
- Upstream protocol violations (dropping in_vld or changing in_dat before acceptance) are not checked. Each word is captured exactly at its push edge.

Test Plan:
- Reset/idle: hold rst 3 cycles with in_vld=1 -> in_rdy=0 throughout; after release in_rdy=1, out_vld=0, out_dat=0, level=0, hwm=0.
- Fill, then drain (DEPTH=4, WIDTH=32):
  - Push 0xA0..0xA3 with out_rdy=0 -> level steps 1,2,3,4; in_rdy=0 at level 4; a fifth word 0xA4 held valid is not accepted.
  - Then set out_rdy=1 -> 0xA0,0xA1,0xA2,0xA3,0xA4 emerge in order; hwm=4.
- Streaming: continuous in_vld=1 and out_rdy=1 for 20 words 0..19 -> one output per cycle after 1-cycle initial latency; level stays 1; out_dat sequence 0..19.
- Full with simultaneous pop: at level=4 assert in_vld=1 and out_rdy=1 -> no push that cycle, level=3 next cycle, in_rdy=1; pointer wrap verified over 3 full fill/drain rounds with random back-pressure against a scoreboard.
- hwm clear:
  - Reach level 3, then drain to 1, pulse hwm_clr -> hwm=1.
  - Push 1 more with no pop -> hwm=2.
  - hwm_clr on the same edge as a push from level 1 -> hwm=2.
- Reset mid-operation: at level=3, assert rst for 1 cycle with out_rdy=1 -> out_vld=0, level=0, hwm=0 next cycle; the next pushed word 0x55 is the first one output.
